// File: rtl/img_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared definitions for the frame capture path:
//   - default image geometry (160 x 100 pixels, 8-bit pixels)
//   - the capture FSM state type used by frame_writer
// No ports; imported with "import img_pkg::*;".
// -----------------------------------------------------------------------------
package img_pkg;

  localparam int IMG_WIDTH      = 160;
  localparam int IMG_HEIGHT     = 100;
  localparam int IMG_PIXELS     = IMG_WIDTH * IMG_HEIGHT;  // 16000
  localparam int IMG_ADDR_WIDTH = 15;                      // 2^15 > 16000
  localparam int PIXEL_WIDTH    = 8;

  // Capture FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DONE     = 2'd3
  } fw_state_e;

endpackage : img_pkg

// File: rtl/ram_sdp.sv
// -----------------------------------------------------------------------------
// ram_sdp
// Simple dual-port frame store: one write port, one registered read port.
// Ports:
//   clk      - clock, all activity on posedge
//   rst_ni   - asynchronous active-low reset (clears the read register only)
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - registered read data (1-cycle latency)
// A read and write to the same address in one cycle returns the old contents.
// Out-of-range addresses never write and read back as zero.
// -----------------------------------------------------------------------------
module ram_sdp #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16000
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  wr_in_range;
  logic                  rd_in_range;

  assign wr_in_range = ({1'b0, waddr_i} < DEPTH_L);
  assign rd_in_range = ({1'b0, raddr_i} < DEPTH_L);

  // Storage array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i && wr_in_range) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (rd_in_range) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule : ram_sdp

// File: rtl/frame_writer.sv
// -----------------------------------------------------------------------------
// frame_writer
// Captures one frame of pixels from a valid/ready stream into a frame store
// each time it is armed by a start pulse, with independent readback.
// Ports:
//   clk        - clock, all logic on posedge
//   rst        - asynchronous active-low reset
//   start      - one-cycle pulse, arms capture of one frame (IDLE only)
//   in_valid   - upstream pixel valid
//   in_sof     - first pixel of a frame, qualified by in_valid
//   in_data    - pixel value
//   in_ready   - pixel accepted this cycle when in_valid is also high
//   rd_addr    - readback address
//   rd_data    - readback data, registered (1-cycle latency)
//   busy       - high while waiting for SOF, writing, or in the done cycle
//   done       - one-cycle pulse when a frame is complete
//   err        - sticky: SOF seen in the middle of a frame
//   frame_cnt  - completed frame count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module frame_writer
  import img_pkg::*;
#(
  parameter int ADDR_WIDTH = IMG_ADDR_WIDTH,
  parameter int DATA_WIDTH = PIXEL_WIDTH,
  parameter int DATA_DEPTH = IMG_PIXELS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            frame_cnt
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  fw_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  err_q, err_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;

  logic                  accept;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;

  // Handshake outputs depend only on state, so they are stable all cycle.
  assign in_ready = (state_q == ST_WAIT_SOF) || (state_q == ST_WRITE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT_SOF;
        end
      end

      ST_WAIT_SOF: begin
        // Beats before the first SOF are dropped.
        if (accept && in_sof) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wr_addr_d = ADDR_ONE;
          state_d   = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (accept) begin
          mem_we = 1'b1;
          if (in_sof && (wr_addr_q != '0)) begin
            // Unexpected SOF: flag it and restart the frame at this pixel.
            err_d     = 1'b1;
            mem_waddr = '0;
            wr_addr_d = ADDR_ONE;
          end else if (wr_addr_q == LAST_ADDR) begin
            wr_addr_d = '0;
            state_d   = ST_DONE;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
          end
        end
      end

      ST_DONE: begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;

  ram_sdp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DATA_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_ni  (rst),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (in_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule : frame_writer

// File: tb/tb_frame_writer.sv
module tb_frame_writer;
  import img_pkg::*;

  localparam int AW   = IMG_ADDR_WIDTH;
  localparam int D    = IMG_PIXELS;
  localparam int S_AW = 3;
  localparam int S_D  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size instance
  logic          rst, start, in_valid, in_sof;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy, done, err;
  logic [7:0]    frame_cnt;

  // Small instance, used for the frame counter wrap
  logic            s_start, s_in_valid, s_in_sof;
  logic [7:0]      s_in_data;
  logic            s_in_ready;
  logic [S_AW-1:0] s_rd_addr;
  logic [7:0]      s_rd_data;
  logic            s_busy, s_done, s_err;
  logic [7:0]      s_frame_cnt;

  frame_writer u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .in_ready(in_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt)
  );

  frame_writer #(.ADDR_WIDTH(S_AW), .DATA_WIDTH(8), .DATA_DEPTH(S_D)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_sof(s_in_sof),
    .in_data(s_in_data), .in_ready(s_in_ready), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .busy(s_busy), .done(s_done), .err(s_err), .frame_cnt(s_frame_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame store contents and the frame currently being built.
  logic [7:0] model_mem [D];
  logic [7:0] frame_q [$];
  bit         armed     = 1'b0;
  bit         exp_err   = 1'b0;
  logic [7:0] exp_cnt   = 8'd0;
  int         frames    = 0;
  int         done_seen = 0;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the full-size instance, with the model tracking the effect.
  task automatic beat(input bit v, input bit sof, input logic [7:0] d, input bit st);
    bit acc;
    in_valid = v; in_sof = sof; in_data = d; start = st;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(armed));
    acc = v && armed;
    tick();
    in_valid = 1'b0; in_sof = 1'b0; start = 1'b0;
    if (st && !armed) armed = 1'b1;
    if (acc) begin
      if (sof) begin
        if (frame_q.size() != 0) exp_err = 1'b1;
        frame_q.delete();
      end
      if (sof || frame_q.size() != 0) begin
        frame_q.push_back(d);
        model_mem[frame_q.size() - 1] = d;
      end
      if (frame_q.size() == D) begin
        frame_q.delete();
        armed = 1'b0;
        exp_cnt++;
        frames++;
        check("done_pulse", 32'(done), 1);
        check("ready_in_done", 32'(in_ready), 0);
        tick();
        check("done_clear", 32'(done), 0);
        check("busy_idle", 32'(busy), 0);
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      end
    end
  endtask

  task automatic rd_check(input int a, input string tag);
    rd_addr = AW'(a);
    tick();
    check(tag, 32'(rd_data), 32'(model_mem[a]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
  endtask

  initial begin
    logic [7:0] old0;
    logic [7:0] s_data [S_D];
    int cnt_before;
    int done_before;
    int budget;

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; rd_addr = '0;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_sof = 1'b0; s_in_data = '0; s_rd_addr = '0;

    // Reset state, before and after clock edges
    #2;
    check_all_zero("rst_async");
    repeat (3) tick();
    check_all_zero("rst_held");
    rst = 1'b1;
    tick();
    check_all_zero("idle");

    // Full frame, data = address
    beat(1'b0, 1'b0, 8'h00, 1'b1);
    check("busy_wait_sof", 32'(busy), 1);
    for (int i = 0; i < D; i++) beat(1'b1, i == 0, 8'(i), 1'b0);
    check("done_count_1", 32'(done_seen), 1);
    rd_addr = AW'(5);
    tick();
    check("rd_addr5", 32'(rd_data), 32'h05);
    rd_check(D - 1, "rd_last");

    // Non-SOF beats while waiting are discarded
    beat(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 8'($urandom), 1'b0);
    rd_check(0, "discard_mem0");
    rd_check(1, "discard_mem1");
    check("busy_after_discard", 32'(busy), 1);
    old0 = model_mem[0];
    rd_addr = '0;
    beat(1'b1, 1'b1, 8'hAA, 1'b0);
    check("rd_during_write_old", 32'(rd_data), 32'(old0));
    rd_check(0, "sof_mem0_AA");
    check("err_clean", 32'(err), 0);

    // Mid-frame SOF at write address 100
    for (int i = 1; i < 100; i++) beat(1'b1, 1'b0, 8'($urandom), 1'b0);
    beat(1'b1, 1'b1, 8'h55, 1'b0);
    check("err_set", 32'(err), 1);
    rd_check(0, "restart_mem0_55");

    // Rest of the frame with random stalls and stray start pulses
    cnt_before = frames;
    budget = 0;
    while (frames == cnt_before && budget < 4 * D) begin
      beat(($urandom % 4) != 0, 1'b0, 8'($urandom), ($urandom % 8) == 0);
      budget++;
    end
    check("stall_frame_complete", frames, cnt_before + 1);
    check("done_count_2", 32'(done_seen), 2);
    check("err_sticky", 32'(err), 1);
    for (int i = 0; i < 4; i++) beat(1'b1, i == 0, 8'($urandom), 1'b0);
    for (int a = 0; a < D; a++) rd_check(a, "mem_readback");

    // Reset in the middle of a frame at write address 500
    beat(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 500; i++) beat(1'b1, i == 0, 8'($urandom), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    armed = 1'b0; frame_q.delete(); exp_err = 1'b0; exp_cnt = 8'd0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("frame_cnt_after_rst", 32'(frame_cnt), 0);
    rd_check(10, "mem_kept");
    done_before = done_seen;
    beat(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 8'($urandom), 1'b0);
    check("needs_sof_busy", 32'(busy), 1);
    rd_check(0, "needs_sof_mem0");
    check("no_done_after_rst", done_seen, done_before);

    // 256 frames on the small instance; start pulses while busy
    for (int f = 0; f < 256; f++) begin
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int k = 0; k < S_D; k++) begin
        s_in_valid = 1'b1; s_in_sof = (k == 0); s_in_data = 8'($urandom);
        s_start = (k == 2);
        s_data[k] = s_in_data;
        tick();
      end
      s_in_valid = 1'b0; s_in_sof = 1'b0; s_start = 1'b1;
      check("s_done", 32'(s_done), 1);
      tick();
      s_start = 1'b0;
      check("s_done_clear", 32'(s_done), 0);
      check("s_busy_idle", 32'(s_busy), 0);
      check("s_frame_cnt", 32'(s_frame_cnt), (f + 1) % 256);
    end
    check("s_wrap_zero", 32'(s_frame_cnt), 0);
    for (int k = 0; k < S_D; k++) begin
      s_rd_addr = S_AW'(k);
      tick();
      check("s_readback", 32'(s_rd_data), 32'(s_data[k]));
    end
    s_rd_addr = S_AW'(5);
    tick();
    s_rd_addr = '0;
    tick();
    check("s_oob_no_effect", 32'(s_rd_data), 32'(s_data[0]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_frame_writer
